// File: rtl/tinyml_cam_rgb2gray_pipe_pkg.sv
// Shared constants and helpers for the RGB-to-gray camera pipeline.
// Reset-time luma weights are BT.601 scaled by 256.
package tinyml_cam_rgb2gray_pipe_pkg;

    localparam int unsigned DEF_COEF_R = 77;
    localparam int unsigned DEF_COEF_G = 150;
    localparam int unsigned DEF_COEF_B = 29;

    // Three products of DATA_WIDTH x COEF_WIDTH need two extra bits to never overflow.
    function automatic int unsigned sum_width(input int unsigned data_width,
                                              input int unsigned coef_width);
        return data_width + coef_width + 2;
    endfunction

endpackage

// File: rtl/tinyml_cam_gray_lane.sv
// One lane of the gray conversion: S1 products, S2 sum, S3 round/saturate.
// All stages advance on en; handshake and valid tracking live in the parent.
module tinyml_cam_gray_lane
    import tinyml_cam_rgb2gray_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned COEF_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] red,
    input  logic [DATA_WIDTH-1:0] green,
    input  logic [DATA_WIDTH-1:0] blue,
    input  logic [COEF_WIDTH-1:0] coef_r,
    input  logic [COEF_WIDTH-1:0] coef_g,
    input  logic [COEF_WIDTH-1:0] coef_b,
    input  logic                  rnd,
    output logic [DATA_WIDTH-1:0] gray
);

    localparam int unsigned PW = DATA_WIDTH + COEF_WIDTH;
    localparam int unsigned SW = sum_width(DATA_WIDTH, COEF_WIDTH);
    localparam logic [SW-1:0] MAX_GRAY = SW'({DATA_WIDTH{1'b1}});
    localparam logic [SW-1:0] HALF_LSB = SW'(1) << (COEF_WIDTH - 1);

    logic [PW-1:0]         prod_r_q, prod_g_q, prod_b_q;
    logic                  rnd_s1_q, rnd_s2_q;
    logic [SW-1:0]         sum_q;
    logic [SW-1:0]         rounded, shifted;
    logic [DATA_WIDTH-1:0] gray_d;

    always_comb begin
        rounded = sum_q + (rnd_s2_q ? HALF_LSB : '0);
        shifted = rounded >> COEF_WIDTH;
        gray_d  = (shifted > MAX_GRAY) ? {DATA_WIDTH{1'b1}} : shifted[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r_q <= '0;
            prod_g_q <= '0;
            prod_b_q <= '0;
            rnd_s1_q <= 1'b0;
            rnd_s2_q <= 1'b0;
            sum_q    <= '0;
            gray     <= '0;
        end else if (en) begin
            prod_r_q <= PW'(red) * PW'(coef_r);
            prod_g_q <= PW'(green) * PW'(coef_g);
            prod_b_q <= PW'(blue) * PW'(coef_b);
            rnd_s1_q <= rnd;
            sum_q    <= SW'(prod_r_q) + SW'(prod_g_q) + SW'(prod_b_q);
            rnd_s2_q <= rnd_s1_q;
            gray     <= gray_d;
        end
    end

endmodule

// File: rtl/tinyml_cam_rgb2gray_pipe.sv
// Multi-lane RGB-to-gray pipeline with frame-latched weights and a single
// stall-all enable derived from the output handshake.
module tinyml_cam_rgb2gray_pipe
    import tinyml_cam_rgb2gray_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PPC        = 2,
    parameter int unsigned COEF_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sof,
    input  logic [PPC*DATA_WIDTH-1:0] in_red,
    input  logic [PPC*DATA_WIDTH-1:0] in_green,
    input  logic [PPC*DATA_WIDTH-1:0] in_blue,
    input  logic [COEF_WIDTH-1:0]     cfg_coef_r,
    input  logic [COEF_WIDTH-1:0]     cfg_coef_g,
    input  logic [COEF_WIDTH-1:0]     cfg_coef_b,
    input  logic                      cfg_round,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sof,
    output logic [PPC*DATA_WIDTH-1:0] out_gray,
    output logic [15:0]               frame_cnt
);

    logic                  en, xfer, sof_xfer;
    logic                  v1_q, v2_q, sof1_q, sof2_q;
    logic [COEF_WIDTH-1:0] sh_coef_r, sh_coef_g, sh_coef_b;
    logic                  sh_round;
    logic [COEF_WIDTH-1:0] coef_r, coef_g, coef_b;
    logic                  rnd;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;
    assign xfer     = in_valid & en;
    assign sof_xfer = xfer & in_sof;

    // The sof beat itself already uses the freshly programmed weights.
    always_comb begin
        coef_r = sof_xfer ? cfg_coef_r : sh_coef_r;
        coef_g = sof_xfer ? cfg_coef_g : sh_coef_g;
        coef_b = sof_xfer ? cfg_coef_b : sh_coef_b;
        rnd    = sof_xfer ? cfg_round  : sh_round;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_coef_r <= COEF_WIDTH'(DEF_COEF_R);
            sh_coef_g <= COEF_WIDTH'(DEF_COEF_G);
            sh_coef_b <= COEF_WIDTH'(DEF_COEF_B);
            sh_round  <= 1'b0;
            frame_cnt <= '0;
        end else if (sof_xfer) begin
            sh_coef_r <= cfg_coef_r;
            sh_coef_g <= cfg_coef_g;
            sh_coef_b <= cfg_coef_b;
            sh_round  <= cfg_round;
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            out_valid <= 1'b0;
            sof1_q    <= 1'b0;
            sof2_q    <= 1'b0;
            out_sof   <= 1'b0;
        end else if (en) begin
            v1_q      <= xfer;
            v2_q      <= v1_q;
            out_valid <= v2_q;
            sof1_q    <= sof_xfer;
            sof2_q    <= sof1_q;
            out_sof   <= sof2_q;
        end
    end

    for (genvar i = 0; i < PPC; i++) begin : g_lane
        tinyml_cam_gray_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .COEF_WIDTH (COEF_WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en),
            .red    (in_red[i*DATA_WIDTH +: DATA_WIDTH]),
            .green  (in_green[i*DATA_WIDTH +: DATA_WIDTH]),
            .blue   (in_blue[i*DATA_WIDTH +: DATA_WIDTH]),
            .coef_r (coef_r),
            .coef_g (coef_g),
            .coef_b (coef_b),
            .rnd    (rnd),
            .gray   (out_gray[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_tinyml_cam_rgb2gray_pipe.sv
// Bench for tinyml_cam_rgb2gray_pipe: table vectors plus scoreboard-checked
// streaming, stall, mid-frame reconfiguration and reset sequences.
module tb_tinyml_cam_rgb2gray_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_sof;
    logic [15:0] in_red, in_green, in_blue;
    logic [7:0]  cfg_coef_r, cfg_coef_g, cfg_coef_b;
    logic        cfg_round;
    logic        out_valid, out_ready, out_sof;
    logic [15:0] out_gray;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    tinyml_cam_rgb2gray_pipe #(
        .DATA_WIDTH (8),
        .PPC        (2),
        .COEF_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sof     (in_sof),
        .in_red     (in_red),
        .in_green   (in_green),
        .in_blue    (in_blue),
        .cfg_coef_r (cfg_coef_r),
        .cfg_coef_g (cfg_coef_g),
        .cfg_coef_b (cfg_coef_b),
        .cfg_round  (cfg_round),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sof    (out_sof),
        .out_gray   (out_gray),
        .frame_cnt  (frame_cnt)
    );

    typedef struct packed {
        logic        sof;
        logic [15:0] gray;
    } beat_t;

    typedef struct packed {
        logic        sof;
        logic [7:0]  cr, cg, cb;
        logic        rnd;
        logic [15:0] r, g, b;
        logic [15:0] exp;
    } vec_t;

    beat_t      sbq[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] m_cr, m_cg, m_cb;
    logic       m_rnd;
    int         m_frames;
    logic       rdy_chk = 1'b0;
    logic       tog_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] gray1(input logic [7:0] r, g, b, cr, cg, cb,
                                         input logic rn);
        int unsigned s;
        s = r * cr + g * cg + b * cb + (rn ? 128 : 0);
        s = s >> 8;
        return (s > 255) ? 8'd255 : s[7:0];
    endfunction

    task automatic model_reset();
        m_cr = 8'd77; m_cg = 8'd150; m_cb = 8'd29; m_rnd = 1'b0; m_frames = 0;
    endtask

    // Drives one beat starting at posedge+1, returns at posedge+1 after its transfer.
    task automatic send(input logic sof, input logic [15:0] r, g, b,
                        input logic use_exp, input logic [15:0] exp);
        beat_t e;
        int    k;
        in_valid = 1'b1; in_sof = sof; in_red = r; in_green = g; in_blue = b;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (k == 50) begin
            chk("in_ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0; in_sof = 1'b0;
            return;
        end
        if (sof) begin
            m_cr = cfg_coef_r; m_cg = cfg_coef_g; m_cb = cfg_coef_b; m_rnd = cfg_round;
            m_frames++;
        end
        e.sof  = sof;
        e.gray = use_exp ? exp : {gray1(r[15:8], g[15:8], b[15:8], m_cr, m_cg, m_cb, m_rnd),
                                  gray1(r[7:0], g[7:0], b[7:0], m_cr, m_cg, m_cb, m_rnd)};
        sbq.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
        chk("drain_all_beats_out", sbq.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic set_cfg(input logic [7:0] cr, cg, cb, input logic rn);
        cfg_coef_r = cr; cfg_coef_g = cg; cfg_coef_b = cb; cfg_round = rn;
    endtask

    // Output monitor: pops the scoreboard on every output transfer.
    initial forever begin
        beat_t e;
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_beat: got out_gray 0x%0h, required no beat", out_gray);
            end else begin
                e = sbq.pop_front();
                chk("out_beat", {15'd0, out_sof, out_gray}, {15'd0, e.sof, e.gray});
            end
        end
        if (rdy_chk) chk("in_ready_is_enable", in_ready, !out_valid || out_ready);
    end

    initial forever begin
        @(posedge clk); #1;
        if (tog_en) out_ready = ~out_ready;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    vec_t vecs[7];

    initial begin
        int f0;
        vecs[0] = '{1'b1, 8'd77, 8'd150, 8'd29, 1'b0, {8'd100, 8'd255}, {8'd100, 8'd255},
                    {8'd100, 8'd255}, {8'd100, 8'd255}};
        vecs[1] = '{1'b1, 8'd77, 8'd150, 8'd29, 1'b1, {8'd0, 8'd255}, 16'h0000, 16'h0000,
                    {8'd0, 8'd77}};
        vecs[2] = '{1'b1, 8'd77, 8'd150, 8'd29, 1'b0, {8'd0, 8'd255}, {8'd255, 8'd0}, 16'h0000,
                    {8'd149, 8'd76}};
        vecs[3] = '{1'b1, 8'd255, 8'd255, 8'd255, 1'b0, {8'd1, 8'd255}, {8'd0, 8'd255},
                    {8'd0, 8'd255}, {8'd0, 8'd255}};
        vecs[4] = '{1'b1, 8'd255, 8'd255, 8'd255, 1'b1, {8'd0, 8'd1}, 16'h0000, {8'd1, 8'd0},
                    {8'd1, 8'd1}};
        // Non-sof beat: cfg must be ignored, 255/255/255 round=1 still active.
        vecs[5] = '{1'b0, 8'd0, 8'd0, 8'd0, 1'b0, {8'd128, 8'd10}, {8'd0, 8'd20},
                    {8'd0, 8'd30}, {8'd128, 8'd60}};
        vecs[6] = '{1'b1, 8'd77, 8'd150, 8'd29, 1'b0, 16'h0000, {8'd255, 8'd0}, {8'd0, 8'd255},
                    {8'd149, 8'd28}};

        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        in_red = '0; in_green = '0; in_blue = '0; out_ready = 1'b1;
        set_cfg(8'd77, 8'd150, 8'd29, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_frame_cnt", frame_cnt, 0);
        chk("reset_out_gray", out_gray, 0);
        chk("reset_out_sof", out_sof, 0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("in_ready_after_reset", in_ready, 1);
        @(posedge clk); #1;

        // Latency: out_valid appears exactly in the third cycle after transfer.
        send(1'b1, {8'd100, 8'd255}, {8'd100, 8'd255}, {8'd100, 8'd255}, 1'b1, {8'd100, 8'd255});
        @(negedge clk); chk("latency_cycle1", out_valid, 0);
        @(negedge clk); chk("latency_cycle2", out_valid, 0);
        @(negedge clk); chk("latency_cycle3", out_valid, 1);
        drain();

        foreach (vecs[i]) begin
            set_cfg(vecs[i].cr, vecs[i].cg, vecs[i].cb, vecs[i].rnd);
            send(vecs[i].sof, vecs[i].r, vecs[i].g, vecs[i].b, 1'b1, vecs[i].exp);
        end
        drain();
        chk("frame_cnt_after_table", frame_cnt, m_frames);

        // Streaming under a 1010 out_ready pattern.
        rdy_chk = 1'b1; tog_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 16'h0);
        end
        drain();
        tog_en = 1'b0; rdy_chk = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;

        // Mid-frame coefficient change takes effect only at the next sof.
        f0 = m_frames;
        set_cfg(8'd77, 8'd150, 8'd29, 1'b0);
        send(1'b1, {8'd200, 8'd100}, {8'd10, 8'd0}, 16'h0000, 1'b0, 16'h0);
        cfg_coef_r = 8'd0;
        send(1'b0, {8'd200, 8'd100}, {8'd10, 8'd0}, 16'h0000, 1'b0, 16'h0);
        send(1'b1, {8'd200, 8'd100}, {8'd10, 8'd0}, 16'h0000, 1'b1, {8'd5, 8'd0});
        drain();
        chk("frame_cnt_two_sofs", frame_cnt, f0 + 2);

        // sof without valid is ignored.
        in_sof = 1'b1;
        repeat (3) @(posedge clk);
        #1 in_sof = 1'b0;
        chk("sof_without_valid", frame_cnt, f0 + 2);

        // Reset with beats in flight.
        set_cfg(8'd77, 8'd150, 8'd29, 1'b0);
        send(1'b1, 16'h1234, 16'h5678, 16'h9abc, 1'b0, 16'h0);
        send(1'b0, 16'h4321, 16'h8765, 16'hcba9, 1'b0, 16'h0);
        send(1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 16'h0);
        chk("pre_reset_out_valid", out_valid, 1);
        rst_n = 1'b0;
        sbq.delete();
        model_reset();
        #1;
        chk("async_reset_out_valid", out_valid, 0);
        chk("async_reset_frame_cnt", frame_cnt, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("in_ready_after_reset2", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_stale_beat", out_valid, 0);
        end
        @(posedge clk); #1;

        // Shadow weights back at 77/150/29 truncate; cfg is ignored off sof.
        set_cfg(8'd0, 8'd0, 8'd0, 1'b1);
        send(1'b0, {8'd0, 8'd255}, 16'h0000, {8'd255, 8'd0}, 1'b1, {8'd28, 8'd76});
        drain();
        chk("frame_cnt_final", frame_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tinyml_cam_rgb2gray_pipe.md
TINYML_CAM_RGB2GRAY_PIPE -- requirements
Module: tinyml_cam_rgb2gray_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per colour component and per gray sample.
REQ-002 Parameter PPC, default 2: pixels per clock (lanes).
REQ-003 Parameter COEF_WIDTH, default 8: unsigned coefficient width; fixed-point scale is 2^COEF_WIDTH.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  input beat valid.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_sof  input  1  beat is first of frame.
REQ-009 in_red, in_green, in_blue  input  PPC*DATA_WIDTH each  lane i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
REQ-010 cfg_coef_r, cfg_coef_g, cfg_coef_b  input  COEF_WIDTH each  programmed weights.
REQ-011 cfg_round  input  1  1 = round-half-up, 0 = truncate.
REQ-012 out_valid  output  1  output beat valid.
REQ-013 out_ready  input  1  downstream accepts.
REQ-014 out_sof  output  1  in_sof delayed with its beat.
REQ-015 out_gray  output  PPC*DATA_WIDTH  lane layout as inputs.
REQ-016 frame_cnt  output  16  count of accepted in_sof beats, wraps 0xFFFF->0.

Function
REQ-017 Transfer occurs on a cycle with valid and ready both high, on either port.
REQ-018 Pipeline is 3 stages: S1 lane products, S2 sum of three products, S3 round/saturate to out registers; latency 3 cycles from input transfer to out_valid with no stall.
REQ-019 Pipeline advance enable = ~out_valid | out_ready; all stages advance together; in_ready = enable.
REQ-020 Each stage carries a valid bit; a stage with valid low is a bubble and does not assert out_valid.
REQ-021 When enable is low, all stage registers including out_gray, out_sof and out_valid hold.
REQ-022 Active coefficients/cfg_round are shadow registers loaded from cfg_* on a transfer with in_sof=1 and used from that beat onward; cfg_* changes at any other time have no effect.
REQ-023 Per lane: sum = R*coef_r + G*coef_g + B*coef_b, width DATA_WIDTH+COEF_WIDTH+2, unsigned, no overflow.
REQ-024 cfg_round=1 adds 2^(COEF_WIDTH-1) before shifting right by COEF_WIDTH; 0 shifts only.
REQ-025 Shifted result above 2^DATA_WIDTH-1 saturates to 2^DATA_WIDTH-1.
REQ-026 Lanes are independent and identical; lane order preserved.
REQ-027 frame_cnt increments on each transfer with in_sof=1, including when simultaneously stalled downstream in later cycles.
REQ-028 in_sof on a non-transferring cycle is ignored.

Reset
REQ-029 On rst_n low: all stage valids, out_valid, out_sof, out_gray, frame_cnt = 0; shadow coefficients = 77/150/29, shadow round = 0.
REQ-030 Reset mid-frame discards in-flight beats; no beat emerges after deassertion unless newly accepted.
REQ-031 in_ready is high in the first cycle after rst_n deasserts.

Structure
REQ-032 Shared package holds default coefficients (77,150,29) and the sum-width function of DATA_WIDTH/COEF_WIDTH.
REQ-033 One sub-module tinyml_cam_gray_lane (one lane's S1-S3 datapath, no handshake), instantiated PPC times via generate; valid/enable/shadow/frame_cnt logic lives in the top module.

Verification
REQ-034 Defaults, round=0, lane0 RGB (255,255,255), lane1 (100,100,100) -> out_gray lanes 255, 100, out_valid exactly 3 cycles after transfer.
REQ-035 sof beat with cfg round=1, default coefs, RGB (255,0,0) -> 77; same with round=0 -> 76.
REQ-036 sof beat with coefs 255/255/255, RGB (255,255,255) -> 255 (saturated); (1,0,0) round=0 -> 0.
REQ-037 Stream 10 beats, out_ready toggled 1010...; -> all 10 outputs in order, none dropped or duplicated, in_ready mirrors enable.
REQ-038 Change cfg_coef_r to 0 mid-frame -> outputs unchanged until next sof transfer, then red contribution 0; frame_cnt increments by 1 per sof.
REQ-039 Assert rst_n low with 2 beats in flight -> out_valid 0 immediately, frame_cnt 0, no stale beat after release.
